// File: rtl/addsub_div_seq_if.sv
// Purpose: request/result bundle between a divider client and addsub_div_seq.
// Latency: none, wires only.
// Backpressure: none; the client must watch busy, because a start while busy is dropped.
// Ports: start/i1/i2 flow client -> divider; busy/done/o1/o2/dz flow divider -> client.
interface addsub_div_seq_if #(
   parameter int WIDTH = 36
);
   logic             start;
   logic [WIDTH-1:0] i1;
   logic [WIDTH-1:0] i2;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] o1;
   logic [WIDTH-1:0] o2;
   logic             dz;

   // master: the client issuing divisions
   modport master (
      output start, i1, i2,
      input  busy, done, o1, o2, dz
   );

   // slave: the divider
   modport slave (
      input  start, i1, i2,
      output busy, done, o1, o2, dz
   );
endinterface

// File: rtl/addsub_div_seq.sv
// Purpose: sequential unsigned restoring divider built on one add/sub datapath.
// Latency: done in cycle +WIDTH+1 after the start cycle (+1 for divide-by-zero).
// Backpressure: start is dropped while busy; there is no queue.
// Ports: clk, reset (async, active-high), bus (slave modport).
//        bus.start/i1/i2 form the request: i1 is the dividend, i2 the divisor.
//        bus.o1 is the quotient, bus.o2 the remainder, bus.dz the divide-by-zero flag.
//        bus.busy and bus.done report progress.
module addsub_div_seq #(
   parameter int WIDTH = 36
) (
   input  logic              clk,
   input  logic              reset,
   addsub_div_seq_if.slave   bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   // Partial remainder. Only the low WIDTH bits are kept. After every
   // iteration R < D <= 2^WIDTH-1 holds, so bit WIDTH of R would always be 0.
   // The full WIDTH+1-bit value exists only as the datapath operand below.
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] quo_q;   // dividend shifting out, quotient shifting in
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH-1:0] o1_q;
   logic [WIDTH-1:0] o2_q;
   logic             dz_q;

   // FSM decode
   logic             load_run;
   logic             load_dz;
   logic             step;
   logic             load_res;

   // --------------------------------------------------------------------
   // Shared add/sub datapath: sum = a + b, or a - b as a + ~b + 1.
   // The divider only uses subtract mode.
   // --------------------------------------------------------------------
   logic             as_sub;
   logic [WIDTH:0]   as_a;
   logic [WIDTH:0]   as_b;
   logic [WIDTH:0]   as_b_eff;
   logic [WIDTH:0]   as_sum;

   assign as_sub   = 1'b1;
   assign as_a     = {rem_q, quo_q[WIDTH-1]};
   assign as_b     = {1'b0, dvs_q};
   assign as_b_eff = as_sub ? ~as_b : as_b;
   assign as_sum   = as_a + as_b_eff + {{WIDTH{1'b0}}, as_sub};

   // Before the shift R < D. So the shifted value is below 2D, and wraps past
   // 2^WIDTH exactly when it is less than D. The MSB of the difference is
   // therefore the borrow.
   logic             trial_ok;
   logic [WIDTH:0]   rem_full_nxt;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   assign trial_ok     = ~as_sum[WIDTH];
   assign rem_full_nxt = trial_ok ? as_sum : as_a;
   assign rem_nxt      = rem_full_nxt[WIDTH-1:0];
   assign quo_nxt      = {quo_q[WIDTH-2:0], trial_ok};

   // --------------------------------------------------------------------
   // FSM
   // --------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      load_run = 1'b0;
      load_dz  = 1'b0;
      step     = 1'b0;
      load_res = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.i2 == '0) begin
                  load_dz = 1'b1;
                  state_d = DONE;
               end else begin
                  load_run = 1'b1;
                  state_d  = RUN;
               end
            end
         end
         RUN: begin
            step = 1'b1;
            // cnt counts the iterations still to go, including this one
            if (cnt_q == CW'(1)) begin
               load_res = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------
   // Datapath and result registers
   // --------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         o1_q  <= '0;
         o2_q  <= '0;
         dz_q  <= 1'b0;
      end else begin
         if (load_run) begin
            rem_q <= '0;
            quo_q <= bus.i1;
            dvs_q <= bus.i2;
            cnt_q <= CW'(WIDTH);
         end else if (step) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - CW'(1);
         end

         // The last iteration's results go straight to the outputs, so they
         // are valid from the first DONE cycle onward.
         if (load_res) begin
            o1_q <= quo_nxt;
            o2_q <= rem_nxt;
            dz_q <= 1'b0;
         end else if (load_dz) begin
            o1_q <= '1;
            o2_q <= bus.i1;
            dz_q <= 1'b1;
         end
      end
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
   assign bus.o1   = o1_q;
   assign bus.o2   = o2_q;
   assign bus.dz   = dz_q;

endmodule

// File: tb/tb_addsub_div_seq.sv
// Purpose: directed, table-driven checks of addsub_div_seq at WIDTH=36.
// Latency: cycle +k means k rising edges after the start cycle (the accepting edge is +1).
// Backpressure: covers a start while busy, a start coincident with done, and reset mid-op.
module tb_addsub_div_seq;

   localparam int W = 36;

   logic clk;
   logic reset;

   addsub_div_seq_if #(.WIDTH(W)) bus ();

   addsub_div_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl [NV];

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] prev_q = '0;
   logic [W-1:0] prev_r = '0;
   logic         prev_dz = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Issue one division and follow it to completion.
   // glitch > 0: at cycle +glitch, pulse start with 50/5 and leave i1/i2 changed.
   // start_at_done: hold start high (9/3) during the done cycle.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic dz, input int lat,
                         input int glitch, input bit start_at_done);
      int k;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.i1    = a;
      bus.i2    = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      k = 1;
      chk("busy_at_plus1", {35'd0, bus.busy}, 36'd1);
      while (bus.done !== 1'b1 && k < 80) begin
         if (k == glitch) begin
            bus.start = 1'b1;
            bus.i1    = 36'd50;
            bus.i2    = 36'd5;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         k++;
         if (k == 2 && lat > 2) begin
            chk("hold_o1_in_run", bus.o1, prev_q);
            chk("hold_o2_in_run", bus.o2, prev_r);
         end
      end
      chk("done_latency", W'(k), W'(lat));
      chk("quotient", bus.o1, q);
      chk("remainder", bus.o2, r);
      chk("dz_flag", {35'd0, bus.dz}, {35'd0, dz});
      if (start_at_done) begin
         bus.start = 1'b1;
         bus.i1    = 36'd9;
         bus.i2    = 36'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("done_one_cycle", {35'd0, bus.done}, 36'd0);
      chk("idle_after_done", {35'd0, bus.busy}, 36'd0);
      if (start_at_done) begin
         chk("hold_o1_after_ignored", bus.o1, q);
      end
      prev_q  = q;
      prev_r  = r;
      prev_dz = dz;
   endtask

   initial begin
      bit seen_done;
      int edges;

      tbl[0]  = '{36'd100,          36'd7,            36'd14,           36'd2,   1'b0, 37};
      tbl[1]  = '{36'hF_FFFF_FFFF,  36'd1,            36'hF_FFFF_FFFF,  36'd0,   1'b0, 37};
      tbl[2]  = '{36'hF_FFFF_FFFF,  36'hF_FFFF_FFFF,  36'd1,            36'd0,   1'b0, 37};
      tbl[3]  = '{36'd3,            36'd10,           36'd0,            36'd3,   1'b0, 37};
      tbl[4]  = '{36'd0,            36'd5,            36'd0,            36'd0,   1'b0, 37};
      tbl[5]  = '{36'd1234,         36'd0,            36'hF_FFFF_FFFF,  36'd1234, 1'b1, 1};
      tbl[6]  = '{36'd9,            36'd3,            36'd3,            36'd0,   1'b0, 37};
      tbl[7]  = '{36'h8_0000_0000,  36'd3,            36'h2_AAAA_AAAA,  36'd2,   1'b0, 37};
      tbl[8]  = '{36'd1000,         36'd1000,         36'd1,            36'd0,   1'b0, 37};
      tbl[9]  = '{36'd999,          36'd1000,         36'd0,            36'd999, 1'b0, 37};
      tbl[10] = '{36'd0,            36'd0,            36'hF_FFFF_FFFF,  36'd0,   1'b1, 1};

      bus.start = 1'b0;
      bus.i1    = '0;
      bus.i2    = '0;
      reset     = 1'b1;
      #23;
      chk("rst_busy", {35'd0, bus.busy}, 36'd0);
      chk("rst_done", {35'd0, bus.done}, 36'd0);
      chk("rst_o1", bus.o1, 36'd0);
      chk("rst_o2", bus.o2, 36'd0);
      chk("rst_dz", {35'd0, bus.dz}, 36'd0);
      reset = 1'b0;

      for (int i = 0; i < NV; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].lat, 0, 1'b0);
      end

      // Divide-by-zero, then a normal op must clear dz
      run_op(36'd1234, 36'd0, 36'hF_FFFF_FFFF, 36'd1234, 1'b1, 1, 0, 1'b0);
      run_op(36'd9, 36'd3, 36'd3, 36'd0, 1'b0, 37, 0, 1'b0);

      // A start while busy, with the operands changed, must not disturb the op
      run_op(36'd100, 36'd7, 36'd14, 36'd2, 1'b0, 37, 10, 1'b0);
      // A start coincident with done must be ignored
      run_op(36'd100, 36'd7, 36'd14, 36'd2, 1'b0, 37, 0, 1'b1);

      // Asynchronous reset mid-RUN
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.i1    = 36'd100;
      bus.i2    = 36'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (19) @(posedge clk);
      #3;
      chk("busy_before_abort", {35'd0, bus.busy}, 36'd1);
      reset = 1'b1;
      #1;
      chk("abort_busy", {35'd0, bus.busy}, 36'd0);
      chk("abort_o1", bus.o1, 36'd0);
      chk("abort_o2", bus.o2, 36'd0);
      chk("abort_dz", {35'd0, bus.dz}, 36'd0);
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      seen_done = 1'b0;
      for (edges = 0; edges < 25; edges++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) seen_done = 1'b1;
      end
      chk("no_done_after_abort", {35'd0, seen_done}, 36'd0);
      prev_q = '0;
      prev_r = '0;
      run_op(36'd81, 36'd9, 36'd9, 36'd0, 1'b0, 37, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
